axis_packet_gen: RTL and testbench

- AXI-Stream packet transmitter that drives one router input port (axis_in_* side of the 5-port router) from a simple command interface.
- Each accepted command produces one packet on a single clock domain:
  - one header flit;
  - cmd_len-1 payload flits, with tlast on the final flit.
- Used as the traffic source in NoC test fabrics; it pairs with a packet sink/checker on router outputs.

---
 rtl/axis_noc_pkg.sv | 33 +++
 rtl/axis_packet_gen.sv | 167 ++++++++++++++++
 tb/tb_axis_packet_gen.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_noc_pkg.sv
// Shared NoC stream definitions: header field offsets, packet FSM states and
// the payload pattern used by both the packet generator and the sink/checker.
package axis_noc_pkg;

  localparam int SEQ_LSB  = 0;
  localparam int LEN_LSB  = 8;
  localparam int SEED_LSB = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } pkt_state_e;

  // Payload flit k: low half is seed+k, high half its bitwise complement.
  function automatic logic [31:0] payload_word(input logic [15:0] seed,
                                               input logic [15:0] k);
    logic [15:0] s;
    s = seed + k;
    return {~s, s};
  endfunction

  function automatic logic [31:0] header_word(input logic [7:0]  seq,
                                              input logic [7:0]  len,
                                              input logic [15:0] seed);
    logic [31:0] w;
    w = '0;
    w[SEQ_LSB  +: 8]  = seq;
    w[LEN_LSB  +: 8]  = len;
    w[SEED_LSB +: 16] = seed;
    return w;
  endfunction

endpackage

// File: rtl/axis_packet_gen.sv
// AXI-Stream packet source: one header flit plus payload flits per command.
// Optional stall counter output enabled by AXIS_PKT_GEN_STALL_STATS_EN.
module axis_packet_gen
  import axis_noc_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                   clk_usr,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [TDEST_WIDTH-1:0] cmd_dest,
  input  logic [TID_WIDTH-1:0]   cmd_tid,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic [15:0]            cmd_seed,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest,
  output logic [15:0]            pkt_count,
  output logic                   busy
`ifdef AXIS_PKT_GEN_STALL_STATS_EN
  ,
  output logic [31:0]            stall_count
`endif
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  pkt_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]   k_q, k_d;
  logic [LEN_WIDTH-1:0]   eff_len_q, eff_len_d;
  logic [15:0]            seed_q, seed_d;
  logic [7:0]             seq_q, seq_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [15:0]            pkt_count_q, pkt_count_d;

  logic                   out_fire;
  logic [LEN_WIDTH-1:0]   cmd_eff_len;
  logic [LEN_WIDTH-1:0]   k_next;

  assign out_fire    = tvalid_q & axis_out_tready;
  assign cmd_eff_len = (cmd_len == '0) ? LEN_ONE : cmd_len;
  assign k_next      = k_q + LEN_ONE;

  always_ff @(posedge clk_usr) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      eff_len_q   <= '0;
      seed_q      <= '0;
      seq_q       <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tid_q       <= '0;
      tdest_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      eff_len_q   <= eff_len_d;
      seed_q      <= seed_d;
      seq_q       <= seq_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      tid_q       <= tid_d;
      tdest_q     <= tdest_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SEND;
      SEND:    if (out_fire && tlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next contents of the registered output stage; tvalid never looks at tready combinationally.
  always_comb begin
    k_d         = k_q;
    eff_len_d   = eff_len_q;
    seed_d      = seed_q;
    seq_d       = seq_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    tid_d       = tid_q;
    tdest_d     = tdest_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          eff_len_d = cmd_eff_len;
          seed_d    = cmd_seed;
          tid_d     = cmd_tid;
          tdest_d   = cmd_dest;
          k_d       = '0;
          tvalid_d  = 1'b1;
          tdata_d   = TDATA_WIDTH'(header_word(seq_q, 8'(cmd_eff_len), cmd_seed));
          tlast_d   = (cmd_eff_len == LEN_ONE);
        end
      end
      SEND: begin
        if (out_fire) begin
          if (tlast_q) begin
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            k_d         = '0;
            seq_d       = seq_q + 8'd1;
            pkt_count_d = pkt_count_q + 16'd1;
          end else begin
            k_d     = k_next;
            tdata_d = TDATA_WIDTH'(payload_word(seed_q, 16'(k_next)));
            tlast_d = (k_next == eff_len_q - LEN_ONE);
          end
        end
      end
      default: begin
        tvalid_d = 1'b0;
      end
    endcase
  end

`ifdef AXIS_PKT_GEN_STALL_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stall_count_d = stall_count_q;
    if (tvalid_q && !axis_out_tready) stall_count_d = sat_inc32(stall_count_q);
  end

  always_ff @(posedge clk_usr) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q == SEND);
  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tdata  = tdata_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tid    = tid_q;
  assign axis_out_tdest  = tdest_q;
  assign pkt_count       = pkt_count_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Scoreboard bench for axis_packet_gen: commands push expected flits into a
// queue, a negedge monitor pops and compares every accepted output flit.
module tb_axis_packet_gen;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  id;
    logic [3:0]  dest;
  } flit_t;

  logic        clk_usr = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_dest = '0;
  logic [1:0]  cmd_tid = '0;
  logic [7:0]  cmd_len = '0;
  logic [15:0] cmd_seed = '0;
  logic        axis_out_tvalid;
  logic        axis_out_tready;
  logic [31:0] axis_out_tdata;
  logic        axis_out_tlast;
  logic [1:0]  axis_out_tid;
  logic [3:0]  axis_out_tdest;
  logic [15:0] pkt_count;
  logic        busy;
`ifdef AXIS_PKT_GEN_STALL_STATS_EN
  logic [31:0] stall_count;
`endif

  axis_packet_gen #(
    .TDATA_WIDTH(32), .TID_WIDTH(2), .TDEST_WIDTH(4), .LEN_WIDTH(8)
  ) dut (
    .clk_usr(clk_usr), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest),
    .cmd_tid(cmd_tid), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
    .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
    .pkt_count(pkt_count), .busy(busy)
`ifdef AXIS_PKT_GEN_STALL_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  initial forever #5 clk_usr = ~clk_usr;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  flit_t       exp_q[$];
  int unsigned hs_cyc[$];
  logic [7:0]  exp_seq = '0;
  logic [15:0] exp_pkts = '0;
  logic [31:0] exp_stall = '0;
  logic        rdy_q[$];
  logic        rdy_rand = 1'b0;
  logic        rdy_fix = 1'b1;

  initial forever begin
    @(posedge clk_usr);
    cyc++;
  end

  initial begin
    axis_out_tready = 1'b0;
    forever begin
      @(posedge clk_usr);
      #2;
      if (rdy_q.size() > 0) axis_out_tready = rdy_q.pop_front();
      else if (rdy_rand)    axis_out_tready = 1'($urandom_range(0, 1));
      else                  axis_out_tready = rdy_fix;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference packet: header {seed, len, seq}, payload k -> {~(seed+k), seed+k}.
  task automatic push_pkt(input logic [3:0] d, input logic [1:0] id, input int len,
                          input logic [15:0] seed);
    int          n;
    flit_t       f;
    logic [15:0] s;
    n = (len == 0) ? 1 : len;
    for (int k = 0; k < n; k++) begin
      if (k == 0) f.data = {seed, 8'(n), exp_seq};
      else begin
        s      = seed + 16'(k);
        f.data = {~s, s};
      end
      f.last = (k == n - 1);
      f.id   = id;
      f.dest = d;
      exp_q.push_back(f);
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  initial begin
    flit_t cur, prev, e;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk_usr);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = {axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest};
        if (prev_stall) begin
          chk("hold_tvalid", 64'(axis_out_tvalid), 64'd1);
          chk("hold_flit", 64'(cur), 64'(prev));
        end
        if (axis_out_tvalid && axis_out_tready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_flit: got 0x%0h expected no flit", cur);
          end else begin
            e = exp_q.pop_front();
            chk("flit", 64'(cur), 64'(e));
            if (e.last) exp_pkts = exp_pkts + 16'd1;
          end
          hs_cyc.push_back(cyc + 1);
        end
        if (axis_out_tvalid && !axis_out_tready) exp_stall = exp_stall + 32'd1;
        prev_stall = axis_out_tvalid && !axis_out_tready;
        prev = cur;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the acceptance edge.
  task automatic send_cmd(input logic [3:0] d, input logic [1:0] id, input int len,
                          input logic [15:0] seed, output int unsigned acc);
    bit ok;
    ok = 1'b0;
    acc = 0;
    cmd_dest = d; cmd_tid = id; cmd_len = 8'(len); cmd_seed = seed;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_usr);
      if (cmd_ready) begin
        push_pkt(d, id, len, seed);
        acc = cyc + 1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL cmd_accept: cmd_ready 0 for 3000 cycles, required 1");
    end
    @(posedge clk_usr);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_usr);
      if (exp_q.size() == 0 && !axis_out_tvalid) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d flits outstanding, required 0", exp_q.size());
    end
    chk("pkt_count", 64'(pkt_count), 64'(exp_pkts));
    chk("busy_idle", 64'(busy), 64'd0);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
`ifdef AXIS_PKT_GEN_STALL_STATS_EN
    chk("stall_count", 64'(stall_count), 64'(exp_stall));
`endif
    @(posedge clk_usr);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_usr);
    #1;
    exp_q.delete();
    hs_cyc.delete();
    exp_seq = '0;
    exp_pkts = '0;
    exp_stall = '0;
    rst = 1'b0;
  endtask

  initial begin
    int unsigned acc;
    int unsigned hs_n;
    logic [31:0] s0;

    repeat (3) @(posedge clk_usr);
    @(negedge clk_usr);
    chk("rst_tvalid", 64'(axis_out_tvalid), 64'd0);
    chk("rst_tlast", 64'(axis_out_tlast), 64'd0);
    chk("rst_tdata", 64'(axis_out_tdata), 64'd0);
    chk("rst_tid_tdest", 64'({axis_out_tid, axis_out_tdest}), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
`ifdef AXIS_PKT_GEN_STALL_STATS_EN
    chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
    @(posedge clk_usr);
    #1;
    rst = 1'b0;

    // Single 4-flit packet at full throughput
    rdy_fix = 1'b1;
    hs_cyc.delete();
    send_cmd(4'd5, 2'd2, 4, 16'h1000, acc);
    drain();
    chk("hs_count_4", 64'(hs_cyc.size()), 64'd4);
    if (hs_cyc.size() >= 4) begin
      chk("first_flit_latency", 64'(hs_cyc[0] - acc), 64'd1);
      chk("flits_consecutive", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);
    end

    // Zero length behaves as a one-flit packet
    hs_cyc.delete();
    send_cmd(4'd3, 2'd1, 0, 16'hBEEF, acc);
    drain();
    chk("hs_count_len0", 64'(hs_cyc.size()), 64'd1);

    // Backpressure pattern 0,0,1,0,1,1 on a 3-flit packet
    hs_cyc.delete();
`ifdef AXIS_PKT_GEN_STALL_STATS_EN
    s0 = stall_count;
`else
    s0 = '0;
`endif
    rdy_fix = 1'b0;
    send_cmd(4'd9, 2'd3, 3, 16'h7FFE, acc);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b1); rdy_q.push_back(1'b1);
    rdy_fix = 1'b1;
    drain();
    chk("hs_count_bp", 64'(hs_cyc.size()), 64'd3);
`ifdef AXIS_PKT_GEN_STALL_STATS_EN
    chk("bp_stall_delta", 64'(stall_count - s0), 64'd3);
`else
    chk("bp_stall_base", 64'(s0), 64'd0);
`endif

    // Back-to-back commands: exactly one idle cycle between packets
    do_reset();
    for (int p = 0; p < 3; p++)
      send_cmd(4'($urandom), 2'($urandom), 2, 16'($urandom), acc);
    drain();
    hs_n = hs_cyc.size();
    chk("hs_count_b2b", 64'(hs_n), 64'd6);
    if (hs_n >= 6) begin
      chk("b2b_within", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
      chk("b2b_gap_1", 64'(hs_cyc[2] - hs_cyc[1]), 64'd2);
      chk("b2b_gap_2", 64'(hs_cyc[4] - hs_cyc[3]), 64'd2);
    end

    // Sequence wrap: 257 one-flit packets under random backpressure
    do_reset();
    rdy_rand = 1'b1;
    for (int p = 0; p < 257; p++)
      send_cmd(4'($urandom), 2'($urandom), int'($urandom_range(0, 1)), 16'($urandom), acc);
    drain();
    chk("wrap_pkt_count", 64'(pkt_count), 64'd257);

    // Reset in the middle of an 8-flit packet
    do_reset();
    rdy_rand = 1'b0;
    rdy_fix = 1'b1;
    send_cmd(4'd7, 2'd0, 8, 16'h4242, acc);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk_usr);
        if (hs_cyc.size() >= 2) seen = 1'b1;
      end
      if (!seen) begin
        n_vec++;
        n_err++;
        $display("FAIL midpkt_wait: %0d flits seen, required 2", hs_cyc.size());
      end
    end
    @(posedge clk_usr);
    #1;
    rst = 1'b1;
    @(posedge clk_usr);
    #1;
    exp_q.delete();
    hs_cyc.delete();
    exp_seq = '0;
    exp_pkts = '0;
    exp_stall = '0;
    rst = 1'b0;
    @(negedge clk_usr);
    chk("midrst_tvalid", 64'(axis_out_tvalid), 64'd0);
    chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk_usr);
    #1;
    send_cmd(4'd1, 2'd1, 3, 16'h0101, acc);
    drain();

    // Randomized traffic, including a maximum-length packet
    rdy_rand = 1'b1;
    for (int p = 0; p < 30; p++)
      send_cmd(4'($urandom), 2'($urandom), int'($urandom_range(0, 10)), 16'($urandom), acc);
    send_cmd(4'($urandom), 2'($urandom), 255, 16'($urandom), acc);
    drain();
    chk("leftover_flits", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
